// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end for the RV32 core family. It owns the fetch PC,
// runs a single-outstanding request/acknowledge handshake towards instruction
// memory and buffers fetched {instruction, PC} pairs in a DEPTH-entry
// prefetch FIFO that the decoder drains. Taken branches and jumps from
// execute flush the queue and restart fetching at the new target.
//
// Optional feature macro: FETCH_IRQ_EN
//   When defined, a level interrupt input redirects fetch to IRQ_VEC,
//   pulses irq_ack_o for one cycle and captures the resume PC in irq_epc_o.
//   When undefined, the interrupt ports and their logic are absent.
//
// Parameters:
//   ADDR_W     fetch address width (>= 3)
//   DEPTH      prefetch FIFO entries (power of two, >= 2)
//   RESET_VEC  first fetch address after reset
//   IRQ_VEC    interrupt target (only with FETCH_IRQ_EN)
//
// Ports:
//   clk_i           clock, all state changes on the rising edge
//   rst_i           synchronous active-high reset
//   imem_req_o      fetch request (combinational from state and occupancy)
//   imem_addr_o     word-aligned fetch address (the fetch PC)
//   imem_ack_i      one-cycle response strobe, imem_rdata_i valid with it
//   imem_rdata_i    fetched instruction word
//   redirect_i      taken branch / jump: flush and refetch
//   redirect_pc_i   redirect target, low two bits ignored
//   instr_o         head-of-queue instruction, 0 when empty
//   instr_pc_o      PC of instr_o, 0 when empty
//   instr_valid_o   queue non-empty
//   instr_ready_i   decoder consumes the head when valid && ready
//   irq_i           level interrupt request          (FETCH_IRQ_EN only)
//   irq_ack_o       one-cycle pulse, interrupt taken (FETCH_IRQ_EN only)
//   irq_epc_o       resume PC captured at irq_ack_o  (FETCH_IRQ_EN only)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(32'h0000_0100)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i
`ifdef FETCH_IRQ_EN
    ,
    input  logic              irq_i,
    output logic              irq_ack_o,
    output logic [ADDR_W-1:0] irq_epc_o
`endif
);

    localparam int unsigned        PTR_W   = $clog2(DEPTH);
    localparam int unsigned        CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  PC_STEP = ADDR_W'(4);

    // IDLE: nothing outstanding. WAIT: one request outstanding whose data
    // will be kept. DISCARD: one request outstanding whose data is stale.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetchState_e;

    fetchState_e       state_q,   state_d;
    logic [ADDR_W-1:0] fetchPc_q, fetchPc_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [PTR_W-1:0]  rdPtr_q,   rdPtr_d;
    logic [PTR_W-1:0]  wrPtr_q,   wrPtr_d;

    logic [31:0]       instrMem_q [DEPTH];
    logic [ADDR_W-1:0] pcMem_q    [DEPTH];

    logic              empty;
    logic              flush;
    logic [ADDR_W-1:0] flushTarget;
    logic [ADDR_W-1:0] redirectAligned;
    logic              doPush;
    logic              doPop;

    // The redirect target is always forced onto a word boundary, so its two
    // low bits never reach any state.
    logic [1:0] unusedRedirectLsbs;
    assign unusedRedirectLsbs = redirect_pc_i[1:0];
    assign redirectAligned    = {redirect_pc_i[ADDR_W-1:2], 2'b00};

    assign empty = (count_q == '0);

`ifdef FETCH_IRQ_EN
    logic              irqTake;
    logic              irqArmed_q, irqArmed_d;
    logic              irqAck_q;
    logic [ADDR_W-1:0] irqEpc_q,   irqEpc_d;

    // An interrupt behaves exactly like a redirect to IRQ_VEC, but a real
    // branch/jump in the same cycle wins. After one is taken the request
    // line must be seen low before another can be accepted, so a held
    // level produces a single acknowledge.
    assign irqTake     = irq_i && !redirect_i && irqArmed_q;
    assign flush       = redirect_i || irqTake;
    assign flushTarget = redirect_i ? redirectAligned
                                    : {IRQ_VEC[ADDR_W-1:2], 2'b00};

    // Re-arm whenever the level is sampled low; the resume PC is the oldest
    // instruction not yet handed to the decoder, or the next fetch address
    // if the queue has nothing in it.
    always_comb begin
        irqArmed_d = irqArmed_q;
        irqEpc_d   = irqEpc_q;
        if (irqTake) begin
            irqArmed_d = 1'b0;
            irqEpc_d   = empty ? fetchPc_q : pcMem_q[rdPtr_q];
        end else if (!irq_i) begin
            irqArmed_d = 1'b1;
        end
    end

    // Interrupt bookkeeping registers, cleared by reset like the rest.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irqArmed_q <= 1'b1;
            irqAck_q   <= 1'b0;
            irqEpc_q   <= '0;
        end else begin
            irqArmed_q <= irqArmed_d;
            irqAck_q   <= irqTake;
            irqEpc_q   <= irqEpc_d;
        end
    end

    assign irq_ack_o = irqAck_q;
    assign irq_epc_o = irqEpc_q;
`else
    assign flush       = redirect_i;
    assign flushTarget = redirectAligned;
`endif

    // Next-state logic for the fetch engine and the FIFO bookkeeping.
    // A request is only raised from IDLE when the queue has room and no
    // flush is happening this cycle, which is what keeps pushes from ever
    // overflowing. A response in WAIT is pushed unless a flush coincides;
    // a response in DISCARD (or an unexpected one in IDLE) is dropped.
    // A flush overrides everything: queue emptied, fetch PC replaced.
    always_comb begin
        state_d    = state_q;
        fetchPc_d  = fetchPc_q;
        count_d    = count_q;
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        doPush     = 1'b0;
        imem_req_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rst_i && !flush && (count_q < DEPTH_C)) begin
                    imem_req_o = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack_i) begin
                    state_d = S_IDLE;
                    if (!flush) begin
                        doPush    = 1'b1;
                        fetchPc_d = fetchPc_q + PC_STEP;
                    end
                end else if (flush) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        doPop = !empty && instr_ready_i && !flush;

        if (flush) begin
            fetchPc_d = flushTarget;
            count_d   = '0;
            rdPtr_d   = '0;
            wrPtr_d   = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register. Reset drops any outstanding request, so a
    // response that straggles in afterwards lands in IDLE and is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            fetchPc_q <= RESET_VEC;
            count_q   <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
            count_q   <= count_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
        end
    end

    // FIFO storage. It needs no reset: the outputs are masked while the
    // count says the queue is empty, so stale contents are never visible.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            instrMem_q[wrPtr_q] <= imem_rdata_i;
            pcMem_q[wrPtr_q]    <= fetchPc_q;
        end
    end

    // Decoder-facing outputs come straight from registered storage, so
    // there is no combinational path from the memory data to the decoder.
    assign imem_addr_o   = fetchPc_q;
    assign instr_valid_o = !empty;
    assign instr_o       = empty ? 32'h0 : instrMem_q[rdPtr_q];
    assign instr_pc_o    = empty ? '0    : pcMem_q[rdPtr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue (DEPTH=4, ADDR_W=32, RESET_VEC=0).
// A table of fill vectors, hand-written redirect / wrap / interrupt
// sequences and a long randomised run are checked against a queue-based
// behavioural model. The interrupt section is active when FETCH_IRQ_EN is
// defined for the build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DEPTH     = 4;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] IRQ_VEC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] instrOut;
    logic [31:0] instrPc;
    logic        instrValid;
    logic        instrReady;
    logic        irq;
`ifdef FETCH_IRQ_EN
    logic        irqAck;
    logic [31:0] irqEpc;
`endif

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_VEC(RESET_VEC),
        .IRQ_VEC  (IRQ_VEC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imemReq),
        .imem_addr_o  (imemAddr),
        .imem_ack_i   (imemAck),
        .imem_rdata_i (imemRdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirectPc),
        .instr_o      (instrOut),
        .instr_pc_o   (instrPc),
        .instr_valid_o(instrValid),
        .instr_ready_i(instrReady)
`ifdef FETCH_IRQ_EN
        ,
        .irq_i        (irq),
        .irq_ack_o    (irqAck),
        .irq_epc_o    (irqEpc)
`endif
    );

    // Behavioural model: the queue is a plain SV queue, and the memory side
    // is just "is a request in flight, and is its answer still wanted".
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      modelQ[$];
    logic [31:0] modelPc;
    bit          modelBusy;
    bit          modelStale;
    bit          modelArmed;
    bit          modelIrqAck;
    logic [31:0] modelEpc;

    int errors = 0;
    int checks = 0;

    logic        snapReq;
    logic [31:0] snapAddr;
    logic        snapValid;
    logic [31:0] snapInstr;
    logic [31:0] snapPc;
    logic        snapIrqAck;
    logic [31:0] snapEpc;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInstr;
        logic [31:0] expPc;
    } vec_t;

    vec_t fillTable[18];

    function automatic vec_t mkVec(input logic ack, input logic [31:0] rdata, input logic ready,
                                   input logic eReq, input logic [31:0] eAddr, input logic eValid,
                                   input logic [31:0] eInstr, input logic [31:0] ePc);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.ready = ready;
        v.expReq = eReq; v.expAddr = eAddr; v.expValid = eValid;
        v.expInstr = eInstr; v.expPc = ePc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic bit modelIrqTake(input logic redir, input logic irqIn);
`ifdef FETCH_IRQ_EN
        return irqIn && !redir && modelArmed;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit modelReqNow(input logic rstIn, input logic redir, input logic irqIn);
        return !rstIn && !modelBusy && (modelQ.size() < DEPTH) && !redir && !modelIrqTake(redir, irqIn);
    endfunction

    // Advance the model across one rising edge using that cycle's inputs.
    task automatic modelEdge(input logic rstIn, input logic redir, input logic [31:0] rpc,
                             input logic ack, input logic [31:0] rdata, input logic ready,
                             input logic irqIn);
        bit          take;
        bit          flush;
        bit          push;
        bit          pop;
        bit          reqIssued;
        logic [31:0] target;
        entry_t      e;
        if (rstIn) begin
            modelQ.delete();
            modelPc     = RESET_VEC;
            modelBusy   = 1'b0;
            modelStale  = 1'b0;
            modelArmed  = 1'b1;
            modelIrqAck = 1'b0;
            modelEpc    = 32'h0;
            return;
        end
        take      = modelIrqTake(redir, irqIn);
        flush     = redir || take;
        target    = redir ? {rpc[31:2], 2'b00} : IRQ_VEC;
        reqIssued = modelReqNow(rstIn, redir, irqIn);
        push      = modelBusy && !modelStale && ack && !flush;
        pop       = (modelQ.size() != 0) && ready && !flush;
        modelIrqAck = take;
        if (take) modelEpc = (modelQ.size() != 0) ? modelQ[0].pc : modelPc;
        if (!irqIn) modelArmed = 1'b1;
        else if (take) modelArmed = 1'b0;
        if (modelBusy && ack) begin
            modelBusy  = 1'b0;
            modelStale = 1'b0;
        end
        if (flush) begin
            modelQ.delete();
            modelPc = target;
            if (modelBusy) modelStale = 1'b1;
        end else begin
            if (pop) void'(modelQ.pop_front());
            if (push) begin
                e.instr = rdata;
                e.pc    = modelPc;
                modelQ.push_back(e);
                modelPc = modelPc + 32'd4;
            end
        end
        if (reqIssued) begin
            modelBusy  = 1'b1;
            modelStale = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs just after the edge, sample and compare
    // on the falling edge, then let the model follow the next rising edge.
    task automatic applyStimulus(input logic rstIn, input logic redir, input logic [31:0] rpc,
                                 input logic ack, input logic [31:0] rdata, input logic ready,
                                 input logic irqIn, input bit modelCheck);
        rst        = rstIn;
        redirect   = redir;
        redirectPc = rpc;
        imemAck    = ack;
        imemRdata  = rdata;
        instrReady = ready;
        irq        = irqIn;
        #4;
        snapReq   = imemReq;
        snapAddr  = imemAddr;
        snapValid = instrValid;
        snapInstr = instrOut;
        snapPc    = instrPc;
`ifdef FETCH_IRQ_EN
        snapIrqAck = irqAck;
        snapEpc    = irqEpc;
`else
        snapIrqAck = 1'b0;
        snapEpc    = 32'h0;
`endif
        if (modelCheck) begin
            checkOutput("imem_req",    snapReq,   modelReqNow(rstIn, redir, irqIn));
            checkOutput("imem_addr",   snapAddr,  modelPc);
            checkOutput("instr_valid", snapValid, modelQ.size() != 0);
            checkOutput("instr",       snapInstr, (modelQ.size() != 0) ? modelQ[0].instr : 32'h0);
            checkOutput("instr_pc",    snapPc,    (modelQ.size() != 0) ? modelQ[0].pc : 32'h0);
`ifdef FETCH_IRQ_EN
            checkOutput("irq_ack",     snapIrqAck, modelIrqAck);
            checkOutput("irq_epc",     snapEpc,    modelEpc);
`endif
        end
        @(posedge clk);
        modelEdge(rstIn, redir, rpc, ack, rdata, ready, irqIn);
        #1;
    endtask

    task automatic simpleCycle(input logic redir, input logic [31:0] rpc, input logic ack,
                               input logic [31:0] rdata, input logic ready, input logic irqIn);
        applyStimulus(1'b0, redir, rpc, ack, rdata, ready, irqIn, 1'b1);
    endtask

    task automatic resetDut(input bit checkFirst);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, checkFirst);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] expectNext;
        int          consumed;
        logic        rIrq;
        logic        rRst;
        logic        rRedir;
        logic [31:0] rPc;
        logic        rAck;
        logic        rReady;

        // Reset-and-fill vectors: ACK two cycles after each request, decoder
        // stalled until the queue is full, then one pop and a push+pop.
        fillTable[0]  = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h00, 1'b0, 32'h0,         32'h0);
        fillTable[1]  = mkVec(1'b0, 32'h0,         1'b0, 1'b0, 32'h00, 1'b0, 32'h0,         32'h0);
        fillTable[2]  = mkVec(1'b1, 32'h1100_0013, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,         32'h0);
        fillTable[3]  = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h04, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[4]  = mkVec(1'b0, 32'h0,         1'b0, 1'b0, 32'h04, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[5]  = mkVec(1'b1, 32'h2200_0093, 1'b0, 1'b0, 32'h04, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[6]  = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h08, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[7]  = mkVec(1'b0, 32'h0,         1'b0, 1'b0, 32'h08, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[8]  = mkVec(1'b1, 32'h3300_0113, 1'b0, 1'b0, 32'h08, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[9]  = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h0C, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[10] = mkVec(1'b0, 32'h0,         1'b0, 1'b0, 32'h0C, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[11] = mkVec(1'b1, 32'h4400_0193, 1'b0, 1'b0, 32'h0C, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[12] = mkVec(1'b0, 32'h0,         1'b0, 1'b0, 32'h10, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[13] = mkVec(1'b0, 32'h0,         1'b0, 1'b0, 32'h10, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[14] = mkVec(1'b0, 32'h0,         1'b1, 1'b0, 32'h10, 1'b1, 32'h1100_0013, 32'h0);
        fillTable[15] = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h10, 1'b1, 32'h2200_0093, 32'h4);
        fillTable[16] = mkVec(1'b1, 32'h5500_0213, 1'b1, 1'b0, 32'h10, 1'b1, 32'h2200_0093, 32'h4);
        fillTable[17] = mkVec(1'b0, 32'h0,         1'b0, 1'b1, 32'h14, 1'b1, 32'h3300_0113, 32'h8);

        rst = 1'b1; redirect = 1'b0; redirectPc = 32'h0; imemAck = 1'b0;
        imemRdata = 32'h0; instrReady = 1'b0; irq = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset and fill");
        resetDut(1'b0);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, fillTable[i].ack, fillTable[i].rdata,
                          fillTable[i].ready, 1'b0, 1'b0);
            checkOutput($sformatf("fill%0d_req", i),   snapReq,   fillTable[i].expReq);
            checkOutput($sformatf("fill%0d_addr", i),  snapAddr,  fillTable[i].expAddr);
            checkOutput($sformatf("fill%0d_valid", i), snapValid, fillTable[i].expValid);
            checkOutput($sformatf("fill%0d_instr", i), snapInstr, fillTable[i].expInstr);
            checkOutput($sformatf("fill%0d_pc", i),    snapPc,    fillTable[i].expPc);
        end

        $display("[TB] streaming");
        resetDut(1'b1);
        expectNext = 32'h0;
        consumed   = 0;
        for (int i = 0; i < 26; i++) begin
            simpleCycle(1'b0, 32'h0, modelBusy, $urandom, 1'b1, 1'b0);
            if (snapValid) begin
                checkOutput("stream_pc", snapPc, expectNext);
                expectNext = expectNext + 32'd4;
                consumed++;
            end
        end
        checkOutput("stream_consumed", consumed, 32'd12);

        $display("[TB] redirect mid-flight");
        resetDut(1'b1);
        simpleCycle(1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 1'b0);
        simpleCycle(1'b1, 32'h203, 1'b0, 32'h0,         1'b0, 1'b0);
        simpleCycle(1'b0, 32'h0,   1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checkOutput("late_ack_valid", snapValid, 1'b0);
        simpleCycle(1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 1'b0);
        checkOutput("redir_req",  snapReq,  1'b1);
        checkOutput("redir_addr", snapAddr, 32'h200);
        simpleCycle(1'b0, 32'h0,   1'b1, 32'hCAFE_0013, 1'b0, 1'b0);
        simpleCycle(1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 1'b0);
        checkOutput("redir_first_pc",    snapPc,    32'h200);
        checkOutput("redir_first_instr", snapInstr, 32'hCAFE_0013);

        $display("[TB] redirect with ack");
        simpleCycle(1'b1, 32'h300, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        simpleCycle(1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 1'b0);
        checkOutput("coincide_valid", snapValid, 1'b0);
        checkOutput("coincide_req",   snapReq,   1'b1);
        checkOutput("coincide_addr",  snapAddr,  32'h300);

        $display("[TB] address wrap");
        simpleCycle(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0, 1'b0);
        simpleCycle(1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0);
        simpleCycle(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0);
        checkOutput("wrap_req_addr", snapAddr, 32'hFFFF_FFFC);
        simpleCycle(1'b0, 32'h0,         1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        simpleCycle(1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0);
        checkOutput("wrap_next_addr", snapAddr, 32'h0);
        checkOutput("wrap_next_req",  snapReq,  1'b1);
        checkOutput("wrap_head_pc",   snapPc,   32'hFFFF_FFFC);

`ifdef FETCH_IRQ_EN
        $display("[TB] interrupt");
        resetDut(1'b1);
        simpleCycle(1'b1, 32'h40, 1'b0, 32'h0,         1'b0, 1'b0);
        simpleCycle(1'b0, 32'h0,  1'b0, 32'h0,         1'b0, 1'b0);
        simpleCycle(1'b0, 32'h0,  1'b1, 32'h0000_1234, 1'b0, 1'b0);
        simpleCycle(1'b0, 32'h0,  1'b0, 32'h0,         1'b0, 1'b1);
        checkOutput("irq_head_pc", snapPc, 32'h40);
        simpleCycle(1'b0, 32'h0,  1'b0, 32'h0,         1'b0, 1'b1);
        checkOutput("irq_pulse", snapIrqAck, 1'b1);
        checkOutput("irq_epc_v", snapEpc,    32'h40);
        checkOutput("irq_fetch", snapAddr,   32'h100);
        checkOutput("irq_flush", snapValid,  1'b0);
        for (int i = 0; i < 4; i++) begin
            simpleCycle(1'b0, 32'h0, modelBusy, 32'h0000_0013, 1'b0, 1'b1);
            checkOutput("irq_held", snapIrqAck, 1'b0);
        end
        simpleCycle(1'b0, 32'h0, modelBusy, 32'h0000_0013, 1'b0, 1'b0);
`endif

        $display("[TB] random");
        resetDut(1'b1);
        rIrq = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rRst   = ($urandom_range(0, 299) == 0);
            rRedir = ($urandom_range(0, 9) == 0);
            rPc    = $urandom;
            if ($urandom_range(0, 7) == 0) rPc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            rAck   = modelBusy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            rReady = ($urandom_range(0, 2) != 0);
`ifdef FETCH_IRQ_EN
            if ($urandom_range(0, 7) == 0) rIrq = !rIrq;
`endif
            applyStimulus(rRst, rRedir, rPc, rAck, $urandom, rReady, rIrq, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the RV32 core family: replaces the combinational next-PC path with a sequenced fetch engine owning the fetch PC, a single-outstanding request/acknowledge handshake to instruction memory, and a DEPTH-entry prefetch FIFO of instruction/PC pairs. It sits between instruction memory and the decoder. Execute redirects it on taken branches and jumps; with the interrupt option built in, it also redirects on interrupts.

## Interface
Parameters:
- ADDR_W, 32: fetch address width, at least 3.
- DEPTH, 4: prefetch FIFO entries, a power of two, at least 2.
- RESET_VEC, 0: first fetch address after reset.
- IRQ_VEC, 32'h0000_0100: interrupt target, used only with FETCH_IRQ_EN.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IMEM_REQ  out  1  fetch request; combinational from state and occupancy.
- IMEM_ADDR  out  ADDR_W  word-aligned fetch address; equals fetch_pc.
- IMEM_ACK  in  1  one-cycle response strobe; RDATA valid in the same cycle.
- IMEM_RDATA  in  32  fetched instruction word.
- REDIRECT  in  1  taken branch or jump; flush and refetch.
- REDIRECT_PC  in  ADDR_W  redirect target; bits [1:0] are forced to 0.
- INSTR  out  32  head-of-queue instruction; 0 when the queue is empty.
- INSTR_PC  out  ADDR_W  PC of INSTR; 0 when the queue is empty.
- INSTR_VALID  out  1  queue non-empty.
- INSTR_READY  in  1  decoder consumes the head when INSTR_VALID && INSTR_READY.
- IRQ  in  1  level interrupt request; present only with FETCH_IRQ_EN.
- IRQ_ACK  out  1  one-cycle pulse when the interrupt is taken; present only with FETCH_IRQ_EN.
- IRQ_EPC  out  ADDR_W  resume PC captured at IRQ_ACK; present only with FETCH_IRQ_EN.

## Operation
State machine states:
- IDLE: no request outstanding.
- WAIT: one request outstanding; the response will be kept.
- DISCARD: one request outstanding; its response is stale and will be dropped.

Transitions (redirect effects are given in the redirect rule below):
- IDLE to WAIT: when IMEM_REQ=1. IMEM_REQ = (state==IDLE) && (count<DEPTH) && !REDIRECT. Memory accepts every request.
- WAIT to IDLE: on IMEM_ACK. Push {IMEM_RDATA, fetch_pc} and set fetch_pc += 4, modulo 2^ADDR_W (wraps to 0).
- WAIT to DISCARD: on REDIRECT without IMEM_ACK in the same cycle.
- WAIT to IDLE with redirect: on REDIRECT with IMEM_ACK in the same cycle. The data is dropped.
- DISCARD to IDLE: on IMEM_ACK. The data is dropped.
- DISCARD with redirect: REDIRECT in DISCARD updates fetch_pc and the state stays DISCARD.
- IDLE with redirect: REDIRECT in IDLE updates fetch_pc and the state stays IDLE. No request is issued that cycle.

Redirect rule:
- Flush the FIFO (count=0) and set fetch_pc = {REDIRECT_PC[ADDR_W-1:2], 2'b00}.
- Any pop or push in the same cycle is suppressed.
- REDIRECT has priority over IRQ, push and pop.

FIFO rules:
- A simultaneous push and pop leaves count unchanged.
- Requests are gated by count<DEPTH, so a push never overflows.
- A pop with INSTR_VALID=0 is ignored.
- An IMEM_ACK in IDLE is a protocol error; it is ignored and the state is unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Reset (RST=1 at an edge): state=IDLE, count=0, fetch_pc=RESET_VEC, INSTR_VALID=0, INSTR=0, INSTR_PC=0, IRQ_ACK=0, IRQ_EPC=0. IMEM_REQ is held at 0 while RST=1.
- Reset mid-operation: an outstanding response arriving after RST is ignored, because the state is IDLE.
- First cycle after reset: IMEM_REQ=1, IMEM_ADDR=RESET_VEC.
- Latency: an IMEM_ACK at edge n makes INSTR_VALID=1 after edge n, provided the queue was empty.
- Throughput: peak is one fetch per two cycles (the request cycle plus the ACK cycle at the earliest).
- After REDIRECT at edge n: INSTR_VALID=0 after edge n. If the state becomes IDLE, IMEM_ADDR equals the target in cycle n+1.
- Queue outputs are driven from registered FIFO storage. No combinational path runs from IMEM_RDATA to INSTR.

## Configuration
- FETCH_IRQ_EN defined:
  - IRQ is sampled each edge. IRQ=1 with REDIRECT=0 is treated as a redirect to IRQ_VEC.
  - IRQ_ACK=1 for one cycle after that edge.
  - IRQ_EPC = INSTR_PC if the queue is non-empty, otherwise fetch_pc.
  - A further IRQ is ignored until IRQ has been sampled low at least once.
- FETCH_IRQ_EN undefined: the IRQ, IRQ_ACK and IRQ_EPC ports and their logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset and fill: release RST with RESET_VEC=0, ACK two cycles after each request, INSTR_READY=0, DEPTH=4. Requests go to 0x0, 0x4, 0x8, 0xC, then IMEM_REQ stays 0. INSTR=first word and INSTR_PC=0.
- Streaming: INSTR_READY=1 and ACK one cycle after each request. Consumed PCs are 0x0, 0x4, 0x8 and so on with no gaps in sequence. count never exceeds 1.
- Redirect mid-flight: REDIRECT_PC=0x203 while in WAIT and before the ACK. The late ACK is dropped, the next IMEM_ADDR=0x200, and the first consumed INSTR_PC is 0x200.
- Redirect coinciding with ACK: both in the same cycle. The queue stays empty and the next request goes to the target in the following cycle.
- Wrap-around: fetch_pc=0xFFFF_FFFC, then ACK. The next IMEM_ADDR is 0x0. FIFO pointers wrap after 5 or more push/pop pairs with no data loss.
- Interrupt (FETCH_IRQ_EN): IRQ=1 with the head INSTR_PC=0x40. One IRQ_ACK pulse, IRQ_EPC=0x40, next fetch from 0x100. Holding IRQ high produces no second ACK.
